// File: rtl/mem_arb_if.sv
// mem_arb_if: requester-side bus of the Ahmes RAM arbiter.
// Two identical request ports (req0 = CPU core, req1 = loader/debug):
//   reqN_valid/we/addr/wdata/lock : requester -> arbiter
//   reqN_ready                    : arbiter -> requester, combinational accept
//   reqN_rvalid/rdata             : arbiter -> requester, read return one cycle later
// master modport = requester view, slave modport = arbiter view.
interface mem_arb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0_valid, req0_we, req0_lock, req0_ready, req0_rvalid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata, req0_rdata;
    logic              req1_valid, req1_we, req1_lock, req1_ready, req1_rvalid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata, req1_rdata;
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata, req0_lock,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_lock,
        input  req0_ready, req0_rvalid, req0_rdata,
        input  req1_ready, req1_rvalid, req1_rdata
    );
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata, req0_lock,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_lock,
        output req0_ready, req0_rvalid, req0_rdata,
        output req1_ready, req1_rvalid, req1_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter / access sequencer for the 256x8 Ahmes RAM.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : both request ports, see mem_arb_if
//   ram_wr_en/address/data_in : combinational drive of the single RAM port
//   ram_data_out    : RAM read data, valid the cycle after a read is issued
// Build option: define MEM_ARB_RR_EN for round-robin arbitration in IDLE,
// otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arb_if.slave          bus,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          rd_pend_q, rd_pend_d, rd_tag_q, rd_tag_d;
    logic          gnt0, gnt1, acc, lock_g, win0;
`ifdef MEM_ARB_RR_EN
    // ptr_q holds the most recently granted port; the other one wins a conflict
    logic          ptr_q, ptr_d;
    assign win0  = ptr_q;
    assign ptr_d = acc ? gnt1 : ptr_q;
`else
    assign win0  = 1'b1;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            ptr_q     <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
`ifdef MEM_ARB_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end
    assign acc    = gnt0 || gnt1;
    assign lock_g = gnt0 ? bus.req0_lock : bus.req1_lock;
    // the transfer that takes ownership counts as the first locked one
    assign cnt_inc = (state_q == IDLE ? '0 : cnt_q) + CW'(1);
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_pend_d = acc && !ram_wr_en;
        rd_tag_d  = acc ? gnt1 : rd_tag_q;
        if (acc) begin
            state_d = (lock_g && cnt_inc < LOCK_MAX_C) ? (gnt1 ? OWN1 : OWN0) : IDLE;
            cnt_d   = (lock_g && cnt_inc < LOCK_MAX_C) ? cnt_inc : '0;
        end
    end
    always_comb begin
        gnt0 = bus.req0_valid && (state_q == OWN0 ||
               (state_q == IDLE && (!bus.req1_valid || win0)));
        gnt1 = bus.req1_valid && (state_q == OWN1 ||
               (state_q == IDLE && (!bus.req0_valid || !win0)));
        ram_wr_en   = (gnt0 && bus.req0_we) || (gnt1 && bus.req1_we);
        ram_address = gnt0 ? bus.req0_addr  : gnt1 ? bus.req1_addr  : '0;
        ram_data_in = gnt0 ? bus.req0_wdata : gnt1 ? bus.req1_wdata : '0;
        bus.req0_ready  = gnt0;
        bus.req1_ready  = gnt1;
        bus.req0_rvalid = rd_pend_q && !rd_tag_q;
        bus.req1_rvalid = rd_pend_q && rd_tag_q;
        bus.req0_rdata  = bus.req0_rvalid ? ram_data_out : '0;
        bus.req1_rdata  = bus.req1_rvalid ? ram_data_out : '0;
    end
endmodule
